// File: rtl/unidade_controle_jogo_param.sv
// Parametrised Moore controller for the sequence-memory game (replay, timed plays, end states).
// Define JOGO_VIDAS_EN to compile in the lives mechanism (state C, `perde_vida`).
module unidade_controle_jogo_param #(
  parameter int ADDR_W         = 4,
  parameter int ROUNDS         = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SHOW_CYCLES    = 1000,
  parameter int GAP_CYCLES     = 250,
  parameter int LIVES          = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              sinal_led,
  output logic [1:0]        vidas,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int DISP_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int DISP_W   = $clog2(DISP_MAX + 1);
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_ROUND = ADDR_W'(ROUNDS - 1);
  localparam logic [DISP_W-1:0] SHOW_LAST  = DISP_W'(SHOW_CYCLES - 1);
  localparam logic [DISP_W-1:0] GAP_LAST   = DISP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
`ifdef JOGO_VIDAS_EN
  localparam logic [1:0] VIDAS_INI = 2'(LIVES);
`else
  localparam logic [1:0] VIDAS_INI = 2'd1;
`endif

  if (ROUNDS < 1 || ROUNDS > 2**ADDR_W || GAP_CYCLES < 1 || LIVES < 1 || LIVES > 3) begin : g_param_check
    $error("unidade_controle_jogo_param: parameter out of range");
  end

  typedef enum logic [3:0] {
    S_INICIAL        = 4'h0,
    S_PREPARACAO     = 4'h1,
    S_INICIA_RODADA  = 4'h2,
    S_EXIBE          = 4'h3,
    S_EXIBE_PAUSA    = 4'h4,
    S_ZERA_ENDERECO  = 4'h5,
    S_ESPERA_JOGADA  = 4'h6,
    S_REGISTRA       = 4'h7,
    S_COMPARACAO     = 4'h8,
    S_ULTIMA_RODADA  = 4'h9,
    S_PROXIMO        = 4'hA,
    S_PROXIMA_RODADA = 4'hB,
    S_PERDE_VIDA     = 4'hC,
    S_FIM_ACERTOU    = 4'hD,
    S_FIM_ERROU      = 4'hE,
    S_FIM_TIMEOUT    = 4'hF
  } estado_t;

  estado_t           estado_q;
  logic [ADDR_W-1:0] endereco_q;
  logic [ADDR_W-1:0] rodada_q;
  logic [1:0]        vidas_q;
  logic [DISP_W-1:0] disp_q;
  logic [TMO_W-1:0]  tmo_q;
`ifdef JOGO_VIDAS_EN
  logic              causa_tmo_q;  // 1: life lost to a timeout, 0: to a wrong play
`endif

  // NOTE: every register here is written with <= in one clocked block; reset is
  // synchronous, so it is just the highest-priority branch of the same if.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= S_INICIAL;
      endereco_q  <= '0;
      rodada_q    <= '0;
      vidas_q     <= VIDAS_INI;
      disp_q      <= '0;
      tmo_q       <= '0;
`ifdef JOGO_VIDAS_EN
      causa_tmo_q <= 1'b0;
`endif
    end else begin
      case (estado_q)
        S_INICIAL: if (iniciar) estado_q <= S_PREPARACAO;
        S_PREPARACAO: begin
          rodada_q   <= '0;
          endereco_q <= '0;
          vidas_q    <= VIDAS_INI;
          estado_q   <= S_INICIA_RODADA;
        end
        S_INICIA_RODADA: begin
          endereco_q <= '0;
          disp_q     <= '0;
          estado_q   <= S_EXIBE;
        end
        S_EXIBE:
          if (disp_q == SHOW_LAST) begin
            disp_q   <= '0;
            estado_q <= (endereco_q == rodada_q) ? S_ZERA_ENDERECO : S_EXIBE_PAUSA;
          end else begin
            disp_q <= disp_q + 1'b1;
          end
        S_EXIBE_PAUSA:
          if (disp_q == GAP_LAST) begin
            disp_q     <= '0;
            endereco_q <= endereco_q + 1'b1;
            estado_q   <= S_EXIBE;
          end else begin
            disp_q <= disp_q + 1'b1;
          end
        S_ZERA_ENDERECO: begin
          endereco_q <= '0;
          tmo_q      <= '0;
          estado_q   <= S_ESPERA_JOGADA;
        end
        S_ESPERA_JOGADA:
          if (jogada) begin
            estado_q <= S_REGISTRA;
          end else if (tmo_q == TMO_LAST) begin
`ifdef JOGO_VIDAS_EN
            causa_tmo_q <= 1'b1;
            estado_q    <= S_PERDE_VIDA;
`else
            estado_q    <= S_FIM_TIMEOUT;
`endif
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        S_REGISTRA: estado_q <= S_COMPARACAO;
        S_COMPARACAO:
          if (!igual) begin
`ifdef JOGO_VIDAS_EN
            causa_tmo_q <= 1'b0;
            estado_q    <= S_PERDE_VIDA;
`else
            estado_q    <= S_FIM_ERROU;
`endif
          end else if (endereco_q == rodada_q) begin
            estado_q <= S_ULTIMA_RODADA;
          end else begin
            estado_q <= S_PROXIMO;
          end
        S_ULTIMA_RODADA:
          estado_q <= (rodada_q == LAST_ROUND) ? S_FIM_ACERTOU : S_PROXIMA_RODADA;
        S_PROXIMO: begin
          endereco_q <= endereco_q + 1'b1;
          tmo_q      <= '0;
          estado_q   <= S_ESPERA_JOGADA;
        end
        S_PROXIMA_RODADA: begin
          rodada_q <= rodada_q + 1'b1;
          estado_q <= S_INICIA_RODADA;
        end
`ifdef JOGO_VIDAS_EN
        S_PERDE_VIDA:
          if (vidas_q == 2'd1) begin
            estado_q <= causa_tmo_q ? S_FIM_TIMEOUT : S_FIM_ERROU;
          end else begin
            vidas_q  <= vidas_q - 1'b1;
            estado_q <= S_INICIA_RODADA;
          end
`endif
        S_FIM_ACERTOU, S_FIM_ERROU, S_FIM_TIMEOUT:
          if (iniciar) estado_q <= S_PREPARACAO;
        default: estado_q <= S_INICIAL;
      endcase
    end
  end

  // NOTE: outputs are pure decodes of the state register, so no input reaches
  // an output combinationally and no latch can be inferred.
  assign db_estado = estado_q;
  assign endereco  = endereco_q;
  assign rodada    = rodada_q;
  assign vidas     = vidas_q;
  assign zeraR     = (estado_q == S_INICIAL) || (estado_q == S_PREPARACAO);
  assign registraR = (estado_q == S_REGISTRA);
  assign sinal_led = (estado_q == S_EXIBE);
  assign acertou   = (estado_q == S_FIM_ACERTOU);
  assign errou     = (estado_q == S_FIM_ERROU);
  assign timeout   = (estado_q == S_FIM_TIMEOUT);
  assign pronto    = acertou || errou || timeout;

endmodule
